// File: rtl/ps2_dev_tx_pkg.sv
//==============================================================================
// Module      : ps2_dev_tx_pkg
// Description : Shared frame constants, FSM encoding and scan codes for the
//               PS/2 device-side transmitter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ps2_dev_tx_pkg;

    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_BIT_HI    = 2'd1,
        ST_BIT_LO    = 2'd2,
        ST_INHIBIT   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] BREAK_PFX   = 8'hF0;
    localparam logic [7:0] EXT_PFX     = 8'hE0;
    localparam logic [7:0] SC_0        = 8'h45;
    localparam logic [7:0] SC_1        = 8'h16;
    localparam logic [7:0] SC_2        = 8'h1E;
    localparam logic [7:0] SC_3        = 8'h26;
    localparam logic [7:0] SC_4        = 8'h25;
    localparam logic [7:0] SC_5        = 8'h2E;
    localparam logic [7:0] SC_6        = 8'h36;
    localparam logic [7:0] SC_7        = 8'h3D;
    localparam logic [7:0] SC_8        = 8'h3E;
    localparam logic [7:0] SC_9        = 8'h46;
    localparam logic [7:0] SC_KP_PLUS  = 8'h79;
    localparam logic [7:0] SC_KP_MINUS = 8'h7B;
    localparam logic [7:0] SC_KP_STAR  = 8'h7C;
    localparam logic [7:0] SC_KP_SLASH = 8'h4A;  // sent behind EXT_PFX
    localparam logic [7:0] SC_ENTER    = 8'h5A;

    // Frame as sent LSB first: start(0), data[7:0], odd parity, stop(1).
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_dev_tx_if.sv
//==============================================================================
// Module      : ps2_dev_tx_if
// Description : Valid/ready scan-code push interface into the PS/2 transmitter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ps2_dev_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface

`default_nettype wire

// File: rtl/ps2_dev_tx_fifo.sv
//==============================================================================
// Module      : ps2_tx_fifo
// Description : Small synchronous circular FIFO with occupancy count.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ps2_tx_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    localparam int c_DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [c_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop  & ~o_empty;

    // Count tops out at exactly 2**AW, so its MSB alone marks full.
    assign o_full   = r_count[AW];
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_rdata  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ps2_dev_tx.sv
//==============================================================================
// Module      : ps2_dev_tx
// Description : PS/2 device-side (keyboard) transmitter with scan-code FIFO.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ps2_dev_tx
    import ps2_dev_tx_pkg::*;
#(
    parameter int CLK_DIV  = 2500,
    parameter int FIFO_AW  = 2,
    parameter int IDLE_CYC = 5000
) (
    input  logic          clk,
    input  logic          rst,
    ps2_dev_tx_if.slave   tx_if,
    input  logic          ps2_clk_i,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe,
    output logic          busy
);

    localparam int                  c_DIV_W       = 16;
    localparam int                  c_IDLE_W      = $clog2(IDLE_CYC + 1);
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST    = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0]  c_SYNC_SETTLE = c_DIV_W'(2);
    localparam logic [c_IDLE_W-1:0] c_IDLE_DONE   = c_IDLE_W'(IDLE_CYC);
    localparam logic [3:0]          c_LAST_BIT    = 4'(PS2_FRAME_BITS - 1);

    logic                      r_clk_meta;
    logic                      r_clk_sync;
    ps2_state_t                r_state;
    logic [c_DIV_W-1:0]        r_div;
    logic [c_IDLE_W-1:0]       r_idle;
    logic [3:0]                r_idx;

    logic                      w_push;
    logic                      w_pop;
    logic [7:0]                w_head;
    logic                      w_full;
    logic                      w_empty;
    logic [FIFO_AW:0]          w_count;
    logic [PS2_FRAME_BITS-1:0] w_frame;
    logic [3:0]                w_next_idx;
    logic                      w_div_last;
    logic                      w_line_idle;

    assign w_push         = tx_if.tx_valid & ~w_full;
    assign tx_if.tx_ready = ~w_full;
    assign w_frame        = ps2_frame(w_head);
    assign w_next_idx     = r_idx + 4'd1;
    assign w_div_last     = (r_div == c_DIV_LAST);
    assign w_line_idle    = r_clk_sync & ~ps2_clk_oe & ~ps2_data_oe;
    assign w_pop          = (r_state == ST_BIT_LO) & w_div_last & (r_idx == c_LAST_BIT);
    assign busy           = (r_state != ST_WAIT_IDLE) | (w_count != '0);

    ps2_tx_fifo #(
        .DW (8),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (tx_if.tx_data),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Released line idles high, so the synchronizer resets to 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
        end else begin
            r_clk_meta <= ps2_clk_i;
            r_clk_sync <= r_clk_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_WAIT_IDLE;
            r_div       <= '0;
            r_idle      <= '0;
            r_idx       <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (!w_line_idle) begin
                        r_idle <= '0;
                    end else if (r_idle != c_IDLE_DONE) begin
                        r_idle <= r_idle + c_IDLE_W'(1);
                    end
                    if (w_line_idle && (r_idle == c_IDLE_DONE) && !w_empty) begin
                        r_state     <= ST_BIT_HI;
                        r_idx       <= '0;
                        r_div       <= '0;
                        ps2_data_oe <= ~w_frame[0];
                    end
                end
                ST_BIT_HI: begin
                    // Early cycles still see our own low clock through the synchronizer.
                    if ((r_div >= c_SYNC_SETTLE) && !r_clk_sync) begin
                        r_state     <= ST_INHIBIT;
                        r_div       <= '0;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                    end else if (w_div_last) begin
                        r_state    <= ST_BIT_LO;
                        r_div      <= '0;
                        ps2_clk_oe <= 1'b1;
                    end else begin
                        r_div <= r_div + c_DIV_W'(1);
                    end
                end
                ST_BIT_LO: begin
                    if (w_div_last) begin
                        r_div      <= '0;
                        ps2_clk_oe <= 1'b0;
                        if (r_idx == c_LAST_BIT) begin
                            r_state     <= ST_WAIT_IDLE;
                            r_idle      <= '0;
                            ps2_data_oe <= 1'b0;
                        end else begin
                            r_state     <= ST_BIT_HI;
                            r_idx       <= w_next_idx;
                            ps2_data_oe <= ~w_frame[w_next_idx];
                        end
                    end else begin
                        r_div <= r_div + c_DIV_W'(1);
                    end
                end
                ST_INHIBIT: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    r_idle      <= '0;
                    if (r_clk_sync) begin
                        r_state <= ST_WAIT_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_WAIT_IDLE;
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
